// File: rtl/digit_serial_mult_ctrl.sv
// Digit-serial multiply sequencer: walks every 2-bit digit pair of two captured
// operands through an external 2x2 multiplier and accumulates the weighted products.
module digit_serial_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic [1:0]           mul_a,
    output logic [1:0]           mul_b,
    input  logic [3:0]           mul_p,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result
);
    localparam int N  = WIDTH / 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               r_state, w_next;
    logic [WIDTH-1:0]     r_a, r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [IW-1:0]        r_i, r_j;
    logic                 w_last, w_accept;
    logic [IW+1:0]        w_sh;
    logic [2*WIDTH-1:0]   w_pp;
    logic [WIDTH-1:0]     w_da, w_db;

    assign w_last = (r_i == IW'(N-1)) && (r_j == IW'(N-1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Handshake outputs depend on state only, so in_ready never sees in_valid/out_ready.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        w_accept  = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_da   = r_a >> {r_i, 1'b0};
    assign w_db   = r_b >> {r_j, 1'b0};
    assign mul_a  = busy ? w_da[1:0] : 2'b00;
    assign mul_b  = busy ? w_db[1:0] : 2'b00;

    // Digit weight is 4^(i+j), i.e. a left shift by 2*(i+j).
    assign w_sh   = {1'b0, r_i, 1'b0} + {1'b0, r_j, 1'b0};
    assign w_pp   = {{(2*WIDTH-4){1'b0}}, mul_p} << w_sh;
    assign result = out_valid ? r_acc : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_i   <= '0;
            r_j   <= '0;
        end else if (w_accept) begin
            r_a   <= op_a;
            r_b   <= op_b;
            r_acc <= '0;
            r_i   <= '0;
            r_j   <= '0;
        end else if (r_state == S_RUN) begin
            r_acc <= r_acc + w_pp;
            if (w_last) begin
                r_i <= '0;
                r_j <= '0;
            end else if (r_j == IW'(N-1)) begin
                r_j <= '0;
                r_i <= r_i + IW'(1);
            end else begin
                r_j <= r_j + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_digit_serial_mult_ctrl.sv
// Directed bench for digit_serial_mult_ctrl: WIDTH=8 and WIDTH=4 instances, each
// paired with a behavioural 2x2 multiplier.
module tb_digit_serial_mult_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready;
    logic [7:0]  op_a, op_b;
    logic        in_ready, busy, out_valid;
    logic [1:0]  mul_a, mul_b;
    logic [3:0]  mul_p;
    logic [15:0] result;

    logic        in_valid4, out_ready4;
    logic [3:0]  op_a4, op_b4;
    logic        in_ready4, busy4, out_valid4;
    logic [1:0]  mul_a4, mul_b4;
    logic [3:0]  mul_p4;
    logic [7:0]  result4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign mul_p  = {2'b00, mul_a}  * {2'b00, mul_b};
    assign mul_p4 = {2'b00, mul_a4} * {2'b00, mul_b4};

    digit_serial_mult_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .result(result));

    digit_serial_mult_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .op_a(op_a4), .op_b(op_b4), .mul_a(mul_a4), .mul_b(mul_b4), .mul_p(mul_p4),
        .busy(busy4), .out_valid(out_valid4), .out_ready(out_ready4), .result(result4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts a/b from IDLE, checks busy length and digit sequencing, checks the product,
    // then releases the result.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input string tag);
        int k;
        logic [7:0] da, db;
        op_a = a; op_b = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 40) begin
            da = a >> (2 * (k / 4));
            db = b >> (2 * (k % 4));
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_mul_a"}, {30'd0, mul_a}, {30'd0, da[1:0]});
            chk({tag, "_mul_b"}, {30'd0, mul_b}, {30'd0, db[1:0]});
            tick();
            k++;
        end
        chk({tag, "_latency"}, k, 16);
        chk({tag, "_result"}, {16'd0, result}, {16'd0, 16'(a) * 16'(b)});
        chk({tag, "_done_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_done_mul"}, {28'd0, mul_a, mul_b}, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_released"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        int k;
        logic [7:0] ra, rb, na, nb;
        logic [15:0] held;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; op_a4 = '0; op_b4 = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        // Test 1: reset mid-idle
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_mul", {28'd0, mul_a, mul_b}, 32'd0);
        chk("rst4_state", {28'd0, in_ready4, busy4, out_valid4, 1'b0}, 32'b1000);
        chk("rst4_result", {24'd0, result4}, 32'd0);

        // Tests 2/3: directed products
        run8(8'hFF, 8'hFF, "ff_ff");
        run8(8'hA5, 8'h3C, "a5_3c");
        run8(8'h00, 8'h7B, "zero");
        run8(8'h01, 8'h01, "one");
        chk("ff_ff_const", 32'(16'(8'hFF) * 16'(8'hFF)), 32'hFE01);

        // Test 4: backpressure with ignored in_valid
        op_a = 8'h12; op_b = 8'h34; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 40) begin tick(); k++; end
        chk("bp_latency", k, 16);
        held = result;
        chk("bp_result", {16'd0, held}, 32'h03A8);
        for (int c = 0; c < 5; c++) begin
            op_a = 8'hEE; op_b = 8'hDD; in_valid = (c == 2);
            tick();
            chk("bp_hold_result", {16'd0, result}, {16'd0, held});
            chk("bp_hold_state", {29'd0, out_valid, in_ready, busy}, 32'b100);
        end
        // release coincides with in_valid: return to IDLE without capture
        out_ready = 1'b1; in_valid = 1'b1;
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        chk("bp_idle", {29'd0, out_valid, in_ready, busy}, 32'b010);
        tick();
        chk("bp_no_capture", {29'd0, out_valid, in_ready, busy}, 32'b010);

        // Test 5: reset during RUN
        op_a = 8'hFF; op_b = 8'hFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c < 7; c++) tick();
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_state", {29'd0, out_valid, in_ready, busy}, 32'b010);
        chk("abort_mul", {28'd0, mul_a, mul_b}, 32'd0);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
        end
        run8(8'h03, 8'h03, "three");

        // Test 6a: WIDTH=4 instance
        op_a4 = 4'hF; op_b4 = 4'hF; in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        k = 0;
        while (!out_valid4 && k < 20) begin tick(); k++; end
        chk("w4_latency", k, 4);
        chk("w4_result", {24'd0, result4}, 32'hE1);
        out_ready4 = 1'b1;
        op_a4 = 4'h6; op_b4 = 4'h7; in_valid4 = 1'b1;
        tick();
        chk("w4_idle", {30'd0, out_valid4, in_ready4}, 32'b01);
        tick();
        in_valid4 = 1'b0;
        k = 0;
        while (!out_valid4 && k < 20) begin tick(); k++; end
        chk("w4_latency2", k, 4);
        chk("w4_result2", {24'd0, result4}, 32'h2A);
        tick();

        // Test 6b: back-to-back random stream with out_ready held high
        out_ready = 1'b1;
        ra = 8'($urandom); rb = 8'($urandom);
        op_a = ra; op_b = rb; in_valid = 1'b1;
        tick();
        for (int n = 0; n < 200; n++) begin
            k = 0;
            while (!out_valid && k < 40) begin tick(); k++; end
            chk("b2b_latency", k, 16);
            chk("b2b_result", {16'd0, result}, {16'd0, 16'(ra) * 16'(rb)});
            na = 8'($urandom); nb = 8'($urandom);
            op_a = na; op_b = nb; in_valid = (n != 199);
            tick();
            chk("b2b_idle", {30'd0, in_ready, busy}, 32'b10);
            tick();
            if (n != 199) chk("b2b_accept", {30'd0, in_ready, busy}, 32'b01);
            ra = na; rb = nb;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/digit_serial_mult_ctrl.md
Name: digit_serial_mult_ctrl

Overview:
Sequential operand sequencer and partial-product accumulator that drives an external 2-bit x 2-bit combinational multiplier. It captures two WIDTH-bit operands and splits each into 2-bit digits. Each cycle it presents one digit pair to the multiplier and adds the 4-bit product, shifted by its digit weight, into a 2*WIDTH-bit accumulator. The block sits directly upstream and downstream of the 2x2 multiplier: it feeds that multiplier's inputs and consumes its product output.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 4; digit count N = WIDTH/2.

Ports:
clk  input  1  single clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand pair valid.
in_ready  output  1  block can accept operands.
op_a  input  WIDTH  multiplicand.
op_b  input  WIDTH  multiplier.
mul_a  output  2  digit of op_a, driven to the 2x2 multiplier.
mul_b  output  2  digit of op_b, driven to the 2x2 multiplier.
mul_p  input  4  product returned combinationally by the 2x2 multiplier in the same cycle.
busy  output  1  high while in RUN.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
result  output  2*WIDTH  op_a * op_b, unsigned.

Behaviour:
- State machine: IDLE, RUN, DONE. Outputs are decoded from state; there is no combinational path from in_valid or out_ready to in_ready.
- Reset: on the rising edge with rst=1, the block goes to IDLE.
  - acc=0, i=0, j=0, captured operands=0.
  - After reset: in_ready=1, busy=0, out_valid=0, result=0, mul_a=0, mul_b=0.
  - Reset takes priority over every other event in every state.
- IDLE:
  - in_ready=1.
  - On in_valid=1, capture op_a/op_b, clear acc, set i=j=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - in_ready=0, busy=1.
  - mul_a = A[2i+1:2i], mul_b = B[2j+1:2j].
  - Each edge: acc <= acc + (mul_p << 2*(i+j)), zero-extended to 2*WIDTH bits. No overflow is possible.
  - Index stepping: j increments; when j=N-1, j wraps to 0 and i increments.
  - On the edge that accumulates pair (N-1,N-1), go to DONE.
  - RUN lasts exactly N*N cycles (16 for WIDTH=8).
- DONE:
  - out_valid=1, result=acc, in_ready=0, mul_a=mul_b=0.
  - Hold result stable until out_ready=1, then go to IDLE on that edge.
- Outside RUN, mul_a and mul_b are 0.
- Latency: out_valid rises N*N cycles after the acceptance edge. Minimum initiation interval is N*N+2 cycles.
- Boundary conditions:
  - in_valid in RUN or DONE is ignored; operands are not sampled.
  - out_ready together with in_valid in DONE: result is released and the block returns to IDLE. The new operand is accepted no earlier than the following edge.
  - out_ready high on the first DONE cycle: result is presented for exactly one cycle.
  - rst mid-RUN or mid-DONE: the operation is aborted with no out_valid pulse, and the partial acc is discarded.
  - Operand 0: the full N*N cycles still run; there is no early termination.
  - mul_p is trusted as given. A faulty multiplier yields a wrong result, and the bench must catch this against a reference model.

Test Plan:
1. Reset check: assert rst for 2 cycles mid-idle -> in_ready=1, out_valid=0, busy=0, result=0, mul_a=mul_b=0.
2. WIDTH=8: op_a=8'hFF, op_b=8'hFF -> busy for 16 cycles; out_valid on cycle 16 after acceptance; result=16'hFE01.
3. WIDTH=8: op_a=8'hA5, op_b=8'h3C -> result=16'h26AC. Also 8'h00 x 8'h7B -> 16'h0000, and 8'h01 x 8'h01 -> 16'h0001, each still 16 busy cycles.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid, pulse in_valid with new operands meanwhile -> result is held constant, in_ready=0, new operands are not captured. Release out_ready -> IDLE next edge.
5. Reset mid-operation: start 8'hFF x 8'hFF, assert rst on cycle 7 of RUN -> no out_valid, state IDLE. Then 8'h03 x 8'h03 -> result=16'h0009.
6. Back-to-back with out_ready tied high, plus a WIDTH=4 instance: 4'hF x 4'hF -> result=8'hE1 after 4 busy cycles. Random 200-op stream on WIDTH=8 matches a behavioural product with the expected initiation interval of 18 cycles.
